ifm_pingpong_bram: RTL

//  Double-buffered (ping-pong) input-feature-map store. The DMA/loader fills one bank while the PE array reads the other.

---
 rtl/ifm_buf_pkg.sv | 17 +
 rtl/ifm_bram_bank.sv | 24 ++
 rtl/ifm_pingpong_bram.sv | 114 +++++++++++
 3 files changed

// File: rtl/ifm_buf_pkg.sv
// rtl/ifm_buf_pkg.sv - shared types and helpers for the ping-pong IFM buffer
// Read latency LAT is 2 when IFM_BUF_OUTREG_EN is defined, otherwise 1.
package ifm_buf_pkg;

  typedef logic bank_id_t;

`ifdef IFM_BUF_OUTREG_EN
  localparam int IFM_BUF_LAT = 2;
`else
  localparam int IFM_BUF_LAT = 1;
`endif

  function automatic int byte_shift(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/ifm_bram_bank.sv
// rtl/ifm_bram_bank.sv - one simple dual-port block RAM bank, registered read
module ifm_bram_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16384,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  (* ram_style = "block" *) logic [DATA_W-1:0] mem [DEPTH];

  // No reset on the array or the read register so the tools can map to BRAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ifm_pingpong_bram.sv
// rtl/ifm_pingpong_bram.sv - double-buffered IFM store with last-beat bank handoff
// Optional IFM_BUF_OUTREG_EN adds an output register after the RAM read (LAT=2).
module ifm_pingpong_bram
  import ifm_buf_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16384,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int BYTE_SH = byte_shift(DATA_W)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      wr_last,
  output logic                      wr_ready,
  input  logic                      rd_en,
  input  logic [ADDR_W+BYTE_SH-1:0] rd_addr,
  input  logic                      rd_last,
  output logic                      rd_bank_ready,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_valid,
  output logic                      err
);

  localparam int LAT = IFM_BUF_LAT;

  bank_id_t          wr_bank;
  bank_id_t          rd_bank;
  bank_id_t          rd_sel;
  logic [1:0]        full;
  logic [LAT-1:0]    vld_pipe;
  logic              wr_acc;
  logic              rd_acc;
  logic [ADDR_W-1:0] rd_word;
  logic [DATA_W-1:0] bank_q [2];
  logic [DATA_W-1:0] ram_q;
  logic              unused_byte_bits;

  assign wr_ready      = !full[wr_bank];
  assign rd_bank_ready = full[rd_bank];
  assign wr_acc        = wr_en && wr_ready;
  assign rd_acc        = rd_en && rd_bank_ready;
  assign rd_word       = rd_addr[BYTE_SH +: ADDR_W];
  assign unused_byte_bits = ^rd_addr;

  // Write and read banks are always distinct when both accept, so no collision.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    ifm_bram_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk     (clk),
      .wr_en   (wr_acc && (wr_bank == bank_id_t'(b))),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (rd_acc && (rd_bank == bank_id_t'(b))),
      .rd_addr (rd_word),
      .rd_data (bank_q[b])
    );
  end

  assign ram_q = bank_q[rd_sel];

  // set/clear land on different bits because acceptance implies a != b
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      rd_sel   <= 1'b0;
      full     <= '0;
      err      <= 1'b0;
      vld_pipe <= '0;
    end else begin
      if (wr_acc && wr_last) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
      end
      if (rd_acc && rd_last) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
      if (rd_acc) rd_sel <= rd_bank;
      if ((wr_en && !wr_ready) || (rd_en && !rd_bank_ready)) err <= 1'b1;
      vld_pipe <= LAT'({vld_pipe, rd_acc});
    end
  end

  assign rd_valid = vld_pipe[LAT-1];

`ifdef IFM_BUF_OUTREG_EN
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              rd_data_q <= '0;
    else if (vld_pipe[0]) rd_data_q <= ram_q;
  end

  assign rd_data = rd_data_q;
`else
  // Bank read registers survive reset; mask them until a read lands after reset.
  logic rd_seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rd_seen <= 1'b0;
    else if (rd_acc) rd_seen <= 1'b1;
  end

  assign rd_data = rd_seen ? ram_q : '0;
`endif

endmodule
